// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NCH sram-like masters onto one sram-like slave port.
// Up to DEPTH outstanding requests are tracked in an in-order ID FIFO so that
// each slave data_ok is steered back to the channel that issued the request.
// Optional feature: define ARB_RR_EN for round-robin arbitration; without it
// the lowest-index requesting channel wins (fixed priority).
module sram_like_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NCH-1:0]           m_req,
    input  logic [NCH-1:0]           m_wr,
    input  logic [2*NCH-1:0]         m_size,
    input  logic [(DATA_W/8)*NCH-1:0] m_wstrb,
    input  logic [ADDR_W*NCH-1:0]    m_addr,
    input  logic [DATA_W*NCH-1:0]    m_wdata,
    output logic [NCH-1:0]           m_addr_ok,
    output logic [NCH-1:0]           m_data_ok,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     s_req,
    output logic                     s_wr,
    output logic [1:0]               s_size,
    output logic [DATA_W/8-1:0]      s_wstrb,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    input  logic                     s_addr_ok,
    input  logic                     s_data_ok,
    input  logic [DATA_W-1:0]        s_rdata
);

    localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    // Per-channel views of the flattened request buses
    logic [1:0]        ch_size  [NCH];
    logic [STRB_W-1:0] ch_wstrb [NCH];
    logic [ADDR_W-1:0] ch_addr  [NCH];
    logic [DATA_W-1:0] ch_wdata [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_size[gi]  = m_size[gi*2 +: 2];
            assign ch_wstrb[gi] = m_wstrb[gi*STRB_W +: STRB_W];
            assign ch_addr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = m_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ID FIFO: small enough that the head entry is read combinationally,
    // which the zero-cycle data_ok routing depends on.
    logic [SEL_W-1:0] id_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             lock;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] sel;
    logic             not_full;
    logic             push;
    logic             pop;

`ifdef ARB_RR_EN
    logic [SEL_W-1:0] rr_ptr;

    // Round-robin winner: first requester at or after rr_ptr, wrapping upward
    always_comb begin
        logic found;
        int   c;
        win   = rr_ptr;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NCH; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= NCH) c = c - NCH;
            if (!found && m_req[c]) begin
                win   = SEL_W'(c);
                found = 1'b1;
            end
        end
    end

    // Pointer moves past the channel granted by the last handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_ptr <= '0;
        else if (push)
            rr_ptr <= (int'(sel) == NCH - 1) ? '0 : sel + 1'b1;
    end
`else
    // Fixed priority winner: lowest-index requesting channel
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && m_req[i]) begin
                win   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end
`endif

    // A stalled request keeps its channel; reset forces channel 0 onto the bus
    assign sel      = !resetn ? '0 : (lock ? lock_ch : win);
    assign not_full = (count != CNT_W'(DEPTH));
    assign s_req    = m_req[sel] && not_full && resetn;
    assign push     = s_req && s_addr_ok;
    assign pop      = s_data_ok && (count != '0) && resetn;

    assign s_wr    = m_wr[sel];
    assign s_size  = ch_size[sel];
    assign s_wstrb = ch_wstrb[sel];
    assign s_addr  = ch_addr[sel];
    assign s_wdata = ch_wdata[sel];
    assign m_rdata = s_rdata;

    // One-hot accept and response strobes back to the masters
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (push) m_addr_ok[sel]        = 1'b1;
        if (pop)  m_data_ok[id_mem[head]] = 1'b1;
    end

    // Hold the selection while the slave has not yet accepted a request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (push) begin
            lock    <= 1'b0;
        end else if (s_req) begin
            lock    <= 1'b1;
            lock_ch <= sel;
        end
    end

    // ID FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) id_mem[i] <= '0;
        end else begin
            if (push) begin
                id_mem[tail] <= sel;
                tail         <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: directed scenarios followed by randomized
// traffic, all checked against a queue-based transaction model.
module tb_sram_like_arbiter;

    localparam int NCH    = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int STRB_W = DATA_W / 8;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic [NCH-1:0]           m_req;
    logic [NCH-1:0]           m_wr;
    logic [2*NCH-1:0]         m_size;
    logic [STRB_W*NCH-1:0]    m_wstrb;
    logic [ADDR_W*NCH-1:0]    m_addr;
    logic [DATA_W*NCH-1:0]    m_wdata;
    logic [NCH-1:0]           m_addr_ok;
    logic [NCH-1:0]           m_data_ok;
    logic [DATA_W-1:0]        m_rdata;
    logic                     s_req;
    logic                     s_wr;
    logic [1:0]               s_size;
    logic [STRB_W-1:0]        s_wstrb;
    logic [ADDR_W-1:0]        s_addr;
    logic [DATA_W-1:0]        s_wdata;
    logic                     s_addr_ok;
    logic                     s_data_ok;
    logic [DATA_W-1:0]        s_rdata;

    sram_like_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction model: queue of issuing channels, plus stall and rr state
    int q[$];
    bit mlock;
    int mlock_ch;
    int mrr;

    int             e_sel;
    bit             e_sreq;
    logic [NCH-1:0] e_aok;
    logic [NCH-1:0] e_dok;
    bit             pend [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int c;
        if (mlock) return mlock_ch;
`ifdef ARB_RR_EN
        for (int k = 0; k < NCH; k++) begin
            c = (mrr + k) % NCH;
            if (m_req[c]) return c;
        end
        return mrr;
`else
        c = 0;
        for (int k = 0; k < NCH; k++) if (m_req[k]) return k;
        return c;
`endif
    endfunction

    task automatic drive(input int ch, input bit req, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic [1:0] sz, input logic [STRB_W-1:0] st);
        m_req[ch]                    = req;
        m_wr[ch]                     = wr;
        m_addr[ch*ADDR_W +: ADDR_W]  = addr;
        m_wdata[ch*DATA_W +: DATA_W] = wd;
        m_size[ch*2 +: 2]            = sz;
        m_wstrb[ch*STRB_W +: STRB_W] = st;
    endtask

    task automatic slave(input bit aok, input bit dok, input logic [DATA_W-1:0] rd);
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = rd;
    endtask

    // Let combinational outputs settle, then compare against the model
    task automatic settle_check();
        #2;
        e_sel  = pick();
        e_sreq = m_req[e_sel] && (q.size() < DEPTH);
        e_aok  = '0;
        e_dok  = '0;
        if (e_sreq && s_addr_ok) e_aok[e_sel] = 1'b1;
        if (s_data_ok && q.size() > 0) e_dok[q[0]] = 1'b1;
        chk("s_req", 64'(s_req), 64'(e_sreq));
        chk("m_addr_ok", 64'(m_addr_ok), 64'(e_aok));
        chk("m_data_ok", 64'(m_data_ok), 64'(e_dok));
        chk("m_rdata", 64'(m_rdata), 64'(s_rdata));
        if (e_sreq) begin
            chk("s_addr", 64'(s_addr), 64'(m_addr[e_sel*ADDR_W +: ADDR_W]));
            chk("s_wdata", 64'(s_wdata), 64'(m_wdata[e_sel*DATA_W +: DATA_W]));
            chk("s_wr", 64'(s_wr), 64'(m_wr[e_sel]));
            chk("s_size", 64'(s_size), 64'(m_size[e_sel*2 +: 2]));
            chk("s_wstrb", 64'(s_wstrb), 64'(m_wstrb[e_sel*STRB_W +: STRB_W]));
        end
    endtask

    // Commit this cycle's transactions to the model and move to the next cycle
    task automatic advance();
        if (e_dok != '0) begin
            $display("resp   ch=%0d rdata=%h", q[0], s_rdata);
            void'(q.pop_front());
        end
        if (e_aok != '0) begin
            $display("accept ch=%0d addr=%h wr=%0d", e_sel, s_addr, m_wr[e_sel]);
            q.push_back(e_sel);
            mrr   = (e_sel + 1) % NCH;
            mlock = 1'b0;
        end else if (e_sreq) begin
            mlock    = 1'b1;
            mlock_ch = e_sel;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        settle_check();
        advance();
    endtask

    initial begin
        logic [NCH-1:0] exp_g;
        q.delete();
        mlock = 0; mlock_ch = 0; mrr = 0;
        for (int i = 0; i < NCH; i++) pend[i] = 0;
        m_req = '0; m_wr = '0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
        resetn = 1'b0;
        // Reset state: requests present but everything gated, fields follow ch0
        drive(0, 1, 1, 32'h0000_1000, 32'h1111_1111, 2'd2, 4'hf);
        drive(1, 1, 0, 32'h0000_2000, 32'h2222_2222, 2'd1, 4'h3);
        slave(1, 1, 32'h5a5a_a5a5);
        #2;
        chk("rst_s_req", 64'(s_req), 64'd0);
        chk("rst_m_addr_ok", 64'(m_addr_ok), 64'd0);
        chk("rst_m_data_ok", 64'(m_data_ok), 64'd0);
        chk("rst_s_addr", 64'(s_addr), 64'h1000);
        chk("rst_m_rdata", 64'(m_rdata), 64'h5a5a_a5a5);
        @(negedge clk);
        resetn = 1'b1;

        // Single read on ch1, response two cycles later
        m_req = '0;
        drive(1, 1, 0, 32'h1c00_0000, 32'h0, 2'd2, 4'h0);
        slave(1, 0, 32'h0);
        settle_check();
        chk("single_aok", 64'(m_addr_ok), 64'h2);
        chk("single_addr", 64'(s_addr), 64'h1c00_0000);
        advance();
        m_req = '0; slave(0, 0, 32'h0);
        cyc();
        slave(0, 1, 32'hdead_beef);
        settle_check();
        chk("single_dok", 64'(m_data_ok), 64'h2);
        chk("single_rdata", 64'(m_rdata), 64'hdead_beef);
        advance();
        slave(0, 1, 32'h0);
        settle_check();
        chk("single_empty", 64'(m_data_ok), 64'h0);
        advance();

        // Contention: both channels request every cycle
        drive(0, 1, 1, 32'h0000_0100, 32'haaaa_0000, 2'd2, 4'hf);
        drive(1, 1, 1, 32'h0000_0200, 32'hbbbb_0000, 2'd2, 4'hf);
        for (int k = 0; k < 4; k++) begin
            slave(1, k > 0, 32'h0);
            settle_check();
`ifdef ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk("contend_grant", 64'(m_addr_ok), 64'(exp_g));
            advance();
        end
        m_req = '0; slave(0, 1, 32'h0);
        cyc();

        // Lock: ch1 stalled, ch0 arrives later but must wait
        drive(1, 1, 0, 32'h0000_0abc, 32'h0, 2'd0, 4'h1);
        slave(0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) drive(0, 1, 0, 32'h0000_0def, 32'h0, 2'd2, 4'hf);
            settle_check();
            chk("lock_addr", 64'(s_addr), 64'h0abc);
            advance();
        end
        slave(1, 0, 32'h0);
        settle_check();
        chk("lock_accept", 64'(m_addr_ok), 64'h2);
        chk("lock_accept_addr", 64'(s_addr), 64'h0abc);
        advance();
        m_req[1] = 1'b0;
        settle_check();
        chk("lock_next", 64'(m_addr_ok), 64'h1);
        advance();
        m_req = '0; slave(0, 1, 32'h0);
        cyc(); cyc();

        // Full: four accepts fill the FIFO, a pop cycle still refuses a request
        drive(0, 1, 0, 32'h0000_4000, 32'h0, 2'd2, 4'hf);
        slave(1, 0, 32'h0);
        for (int k = 0; k < DEPTH; k++) cyc();
        slave(1, 1, 32'h0);
        settle_check();
        chk("full_sreq", 64'(s_req), 64'h0);
        chk("full_aok", 64'(m_addr_ok), 64'h0);
        advance();
        slave(1, 0, 32'h0);
        settle_check();
        chk("full_next_aok", 64'(m_addr_ok), 64'h1);
        advance();
        m_req = '0; slave(0, 1, 32'h0);
        for (int k = 0; k < DEPTH; k++) cyc();

        // Ordering: ch0, ch1, ch1, ch0 then four responses
        slave(1, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            m_req = '0;
            if (k == 0 || k == 3) drive(0, 1, 0, 32'h100 + 32'(k), 32'h0, 2'd2, 4'hf);
            else                  drive(1, 1, 0, 32'h200 + 32'(k), 32'h0, 2'd2, 4'hf);
            cyc();
        end
        m_req = '0;
        for (int k = 0; k < 5; k++) begin
            slave(0, 1, 32'hc0de_0000 + 32'(k));
            settle_check();
            case (k)
                0, 3:    exp_g = 2'b01;
                1, 2:    exp_g = 2'b10;
                default: exp_g = 2'b00;
            endcase
            chk("order_dok", 64'(m_data_ok), 64'(exp_g));
            advance();
        end

        // Randomized traffic with masters holding requests until accepted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1;
                    drive(i, 1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                          2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
                end
                m_req[i] = pend[i];
            end
            slave($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, $urandom);
            settle_check();
            for (int i = 0; i < NCH; i++) if (e_aok[i]) pend[i] = 0;
            advance();
        end
        m_req = '0;
        for (int i = 0; i < NCH; i++) pend[i] = 0;
        slave(0, 1, 32'h0);
        for (int k = 0; k < DEPTH + 1; k++) cyc();

        // Asynchronous reset with three outstanding and a stalled request
        slave(1, 0, 32'h0);
        drive(0, 1, 0, 32'h0000_7000, 32'h0, 2'd2, 4'hf);
        for (int k = 0; k < 3; k++) cyc();
        m_req = '0;
        drive(1, 1, 0, 32'h0000_7100, 32'h0, 2'd2, 4'hf);
        slave(0, 0, 32'h0);
        cyc();
        drive(0, 1, 0, 32'h0000_7000, 32'h0, 2'd2, 4'hf);
        slave(1, 1, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_s_req", 64'(s_req), 64'h0);
        chk("arst_aok", 64'(m_addr_ok), 64'h0);
        chk("arst_dok", 64'(m_data_ok), 64'h0);
        q.delete();
        mlock = 0; mlock_ch = 0; mrr = 0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        m_req = '0;
        slave(0, 1, 32'h0);
        settle_check();
        chk("arst_spurious", 64'(m_data_ok), 64'h0);
        advance();
        drive(0, 1, 0, 32'h0000_7200, 32'h0, 2'd2, 4'hf);
        slave(1, 0, 32'h0);
        settle_check();
        chk("arst_unlocked", 64'(m_addr_ok), 64'h1);
        advance();
        m_req = '0;
        slave(0, 1, 32'h0);
        settle_check();
        chk("arst_resp", 64'(m_data_ok), 64'h1);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter that merges several CPU-side sram-like masters into one sram-like slave port. Masters are instruction fetch, data access and later additions; each uses req/addr_ok/data_ok handshakes. The block sits between the pipeline stages in the CPU top and the bus bridge. It tracks up to DEPTH outstanding transactions in an in-order ID FIFO, so each data_ok is routed back to the channel that issued the request.

## Interface
- NCH, 2, number of master channels (2..8); channel 0 has highest fixed priority
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- DEPTH, 4, max outstanding transactions (power of 2, ≥2)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- m_req  in  NCH  per-channel request
- m_wr  in  NCH  per-channel write flag
- m_size  in  2*NCH  per-channel size (0=byte, 1=half, 2=word), channel i at [2i+1:2i]
- m_wstrb  in  (DATA_W/8)*NCH  per-channel byte strobes
- m_addr  in  ADDR_W*NCH  per-channel address
- m_wdata  in  DATA_W*NCH  per-channel write data
- m_addr_ok  out  NCH  per-channel request accepted
- m_data_ok  out  NCH  per-channel response (read data valid / write done)
- m_rdata  out  DATA_W  read data, shared by all channels
- s_req, s_wr, s_size[1:0], s_wstrb[DATA_W/8-1:0], s_addr[ADDR_W-1:0], s_wdata[DATA_W-1:0]  out  slave request fields
- s_addr_ok  in  1  slave accepted request
- s_data_ok  in  1  slave response
- s_rdata  in  DATA_W  slave read data

## Operation
- State:
  - ID FIFO, DEPTH entries × clog2(NCH) bits, with head/tail pointers and count 0..DEPTH.
  - lock flag and lock_ch.
  - rr_ptr, used only when ARB_RR_EN is defined.
- Selection:
  - If lock=1, sel=lock_ch.
  - Otherwise sel is the arbitration winner among asserted m_req bits.
- s_req = m_req[sel] && count<DEPTH && resetn. All other s_* fields are muxed from channel sel.
- lock is set when s_req=1 and s_addr_ok=0; it captures sel. lock clears on a handshake. This keeps the slave request stable until accepted, as sram-like requires.
- Handshake (s_req && s_addr_ok):
  - m_addr_ok[sel]=1 in the same cycle.
  - sel is pushed to the FIFO tail.
  - With ARB_RR_EN, rr_ptr←(sel+1) mod NCH.
- Response (s_data_ok && count>0):
  - m_data_ok[head]=1 in the same cycle.
  - The head entry is popped.
- m_rdata = s_rdata always; it is pass-through and unregistered.
- Simultaneous push and pop: count stays unchanged and both pointers advance.
- Full (count==DEPTH): s_req=0 even if a pop occurs in the same cycle. The new request is accepted the next cycle at the earliest.
- Empty with s_data_ok: the response is spurious and ignored. No m_data_ok is asserted and count stays 0.
- Pointer wrap: head and tail wrap modulo DEPTH.
- Responses are in order. A channel may hold several outstanding entries.
- Reset (async, any time): FIFO, count, lock and rr_ptr are cleared to 0. Outstanding responses are discarded.

## Timing
- Outputs while resetn=0: s_req=0, m_addr_ok=0, m_data_ok=0. s_* fields follow channel 0; m_rdata follows s_rdata.
- Request path is combinational, 0 cycles: m_req → s_req, and s_addr_ok → m_addr_ok.
- Response path is combinational, 0 cycles: s_data_ok → m_data_ok.
- Minimum request-to-response latency through the block is 0 added cycles. Bus latency is owned by the slave.
- A FIFO push is visible to the pop logic from the next cycle. A same-cycle addr_ok plus data_ok on an empty FIFO is spurious.
- Throughput: one request and one response per cycle.

## Configuration
- ARB_RR_EN defined:
  - Round-robin arbitration.
  - The winner is the first requesting channel at or after rr_ptr, scanning upward modulo NCH.
- ARB_RR_EN undefined:
  - Fixed priority; the lowest-index requesting channel wins.
  - rr_ptr is not implemented.

## Test plan
- Single read, NCH=2: ch1 requests addr 0x1c000000, s_addr_ok=1 → m_addr_ok=2'b10 that cycle. Two cycles later s_data_ok=1, s_rdata=0xdeadbeef → m_data_ok=2'b10, m_rdata=0xdeadbeef, count returns to 0.
- Contention, fixed priority: ch0 and ch1 both request every cycle, s_addr_ok=1 → ch0 is granted every cycle. With ARB_RR_EN, grants alternate 0,1,0,1.
- Lock: ch1 requests alone, s_addr_ok=0 for 3 cycles, ch0 raises m_req in cycle 2 → s_addr stays ch1's through the eventual accept. ch0 is granted the cycle after.
- Full, DEPTH=4: 4 accepted requests with no data_ok → 5th cycle s_req=0. data_ok in that cycle → still no accept. Accept occurs the next cycle.
- Ordering: issue ch0, ch1, ch1, ch0, then 4 data_ok pulses → m_data_ok sequence 01,10,10,01. A data_ok with the FIFO empty produces no m_data_ok.
- Async reset: drop resetn mid-cycle with 3 outstanding and lock=1 → s_req and all ok outputs go 0 immediately, count=0. After release, the first data_ok is ignored.
